traceback_unit: RTL and testbench
=================================

TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 Parameter NUM_STATES, default 4: trellis states (K=3, 2-bit state index).
REQ-002 Parameter DEPTH, default 8: survivor frames per traceback block.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 we  in  1  write enable from controller: store surv_in this cycle.
REQ-006 te  in  1  traceback enable from controller: perform one traceback step.
REQ-007 oe  in  1  output enable from controller: emit decoded bit of current step.
REQ-008 surv_in  in  NUM_STATES  ACS decision bits, bit i = survivor decision for state i.
REQ-009 start_state  in  2  minimum-metric state from ACS, valid on first te cycle of a block.
REQ-010 wr_cnt  out  4  number of frames stored in current block (0..DEPTH).
REQ-011 tb_cnt  out  4  traceback steps remaining (DEPTH..0).
REQ-012 bit_out  out  1  serial decoded bit, reverse time order.
REQ-013 bit_valid  out  1  one-cycle qualifier for bit_out.
REQ-014 frame_out  out  DEPTH  decoded block, bit j = decoded bit of frame j (chronological).
REQ-015 frame_valid  out  1  one-cycle pulse, frame_out complete.

Function
REQ-016 Write: we=1 and wr_cnt<DEPTH -> mem[wr_cnt] <= surv_in, wr_cnt <= wr_cnt+1.
REQ-017 we=1 with wr_cnt==DEPTH is ignored (no write, no count change).
REQ-018 Write of entry DEPTH-1 loads tb_cnt <= DEPTH in the same edge.
REQ-019 Step: te=1, we=0, tb_cnt>0 -> idx=tb_cnt-1, cur = (first step of block ? start_state : state_reg).
REQ-020 Step decoded bit = cur[1]; frame_out[idx] <= cur[1].
REQ-021 Step predecessor: state_reg <= {cur[0], mem[idx][cur]}; tb_cnt <= tb_cnt-1.
REQ-022 First step of block = step taken when tb_cnt==DEPTH.
REQ-023 te=1 with tb_cnt==0 ignored; te ignored whenever we=1 (write has priority).
REQ-024 oe=1 on a valid step -> bit_out <= cur[1], bit_valid <= 1 on next cycle (latency 1); else bit_valid <= 0.
REQ-025 Step with tb_cnt==1 -> frame_valid=1 next cycle (one cycle), wr_cnt <= 0 same edge, ready for next block.
REQ-026 frame_out holds value until overwritten by next block's steps.
REQ-027 Memory not read-before-written check: stale entries used as-is if controller misbehaves; no error flag.

Reset
REQ-028 rst_n low: wr_cnt=0, tb_cnt=0, state_reg=0, bit_out=0, bit_valid=0, frame_out=0, frame_valid=0 immediately.
REQ-029 Survivor memory contents not reset; reset mid-block abandons block, next block starts at wr_cnt=0.

Structure
REQ-030 Package viterbi_pkg SHALL hold NUM_STATES, DEPTH, state width (2) and counter width (4) constants shared with control unit and ACS.
REQ-031 Sub-module survivor_mem: DEPTH x NUM_STATES register array, one sync write port, one async read port (row idx).
REQ-032 Counters and traceback datapath remain in traceback_unit; no internal FSM beyond counters and first-step flag.

Verification
REQ-033 8 writes surv_in=4'hF, start_state=2'b11, 8 te+oe steps -> bit_out all 1, frame_out=8'hFF, frame_valid one pulse.
REQ-034 8 writes surv_in=4'h0, start_state=2'b01 -> serial bits 0,1,0,0,0,0,0,0; frame_out=8'h40.
REQ-035 Counter handshake: wr_cnt 0..8 over writes, tb_cnt=8 after 8th write, decrements to 0, wr_cnt returns 0 with frame_valid.
REQ-036 te with oe=0 -> frame_out updated, bit_valid stays 0; extra we at wr_cnt=8 and te at tb_cnt=0 cause no change.
REQ-037 Simultaneous we and te during traceback -> te ignored, step delayed; rst_n low after 4 steps -> all outputs 0, next block decodes correctly.
REQ-038 Two back-to-back blocks -> second frame_out independent of first, start_state resampled.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Constants shared by the Viterbi ACS, control and traceback blocks.
// Sizes are for K=3: four trellis states, eight-frame traceback blocks.
package viterbi_pkg;
   localparam int NUM_STATES = 4;
   localparam int DEPTH      = 8;
   localparam int STATE_W    = 2;
   localparam int CNT_W      = 4;

   typedef logic [STATE_W-1:0] state_t;
   typedef logic [CNT_W-1:0]   cnt_t;
endpackage

// File: rtl/survivor_mem.sv
// Survivor decision store: DEPTH rows of NUM_STATES decision bits.
// One synchronous write port, one combinational read port; contents are not reset.
module survivor_mem
   import viterbi_pkg::*;
#(
   parameter int NUM_STATES = viterbi_pkg::NUM_STATES,
   parameter int DEPTH      = viterbi_pkg::DEPTH
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [NUM_STATES-1:0]    wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [NUM_STATES-1:0]    rd_data
);
   logic [NUM_STATES-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback: stores DEPTH survivor frames, then walks back one frame per te step.
// Serial bit appears one cycle after its step; the full frame is flagged after the last step.
module traceback_unit
   import viterbi_pkg::*;
#(
   parameter int NUM_STATES = viterbi_pkg::NUM_STATES,
   parameter int DEPTH      = viterbi_pkg::DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic                  te,
   input  logic                  oe,
   input  logic [NUM_STATES-1:0] surv_in,
   input  logic [STATE_W-1:0]    start_state,
   output logic [CNT_W-1:0]      wr_cnt,
   output logic [CNT_W-1:0]      tb_cnt,
   output logic                  bit_out,
   output logic                  bit_valid,
   output logic [DEPTH-1:0]      frame_out,
   output logic                  frame_valid
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [STATE_W-1:0]    state_reg;
   logic [STATE_W-1:0]    cur;
   logic [NUM_STATES-1:0] rd_row;
   logic [ADDR_W-1:0]     wr_addr;
   logic [ADDR_W-1:0]     rd_addr;
   logic                  do_write;
   logic                  do_step;
   logic                  first_step;
   logic                  surv_bit;

   always_comb begin
      do_write   = we && (wr_cnt < CNT_FULL);
      // A write request always wins the cycle, even when the block is full.
      do_step    = te && !we && (tb_cnt != '0);
      first_step = (tb_cnt == CNT_FULL);
      cur        = first_step ? start_state : state_reg;
      wr_addr    = ADDR_W'(wr_cnt);
      rd_addr    = ADDR_W'(tb_cnt - 1'b1);
      surv_bit   = rd_row[cur];
   end

   survivor_mem #(
      .NUM_STATES (NUM_STATES),
      .DEPTH      (DEPTH)
   ) u_survivor_mem (
      .clk     (clk),
      .wr_en   (do_write),
      .wr_addr (wr_addr),
      .wr_data (surv_in),
      .rd_addr (rd_addr),
      .rd_data (rd_row)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt      <= '0;
         tb_cnt      <= '0;
         state_reg   <= '0;
         bit_out     <= 1'b0;
         bit_valid   <= 1'b0;
         frame_out   <= '0;
         frame_valid <= 1'b0;
      end else begin
         bit_valid   <= 1'b0;
         frame_valid <= 1'b0;
         if (do_write) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == CNT_FULL - 1'b1) begin
               tb_cnt <= CNT_FULL;
            end
         end else if (do_step) begin
            frame_out[rd_addr] <= cur[1];
            // Predecessor: shift the state left, pulling in the survivor decision.
            state_reg          <= {cur[0], surv_bit};
            tb_cnt             <= tb_cnt - 1'b1;
            if (oe) begin
               bit_out   <= cur[1];
               bit_valid <= 1'b1;
            end
            if (tb_cnt == CNT_W'(1)) begin
               frame_valid <= 1'b1;
               wr_cnt      <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: block-level reference model checked every cycle,
// plus literal expectations for the known decode patterns.
module tb_traceback_unit;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       we = 1'b0, te = 1'b0, oe = 1'b0;
   logic [3:0] surv_in = '0;
   logic [1:0] start_state = '0;
   logic [3:0] wr_cnt, tb_cnt;
   logic       bit_out, bit_valid, frame_valid;
   logic [7:0] frame_out;

   int n_pass = 0;
   int n_total = 0;

   traceback_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .we          (we),
      .te          (te),
      .oe          (oe),
      .surv_in     (surv_in),
      .start_state (start_state),
      .wr_cnt      (wr_cnt),
      .tb_cnt      (tb_cnt),
      .bit_out     (bit_out),
      .bit_valid   (bit_valid),
      .frame_out   (frame_out),
      .frame_valid (frame_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: the decoded path of a block is worked out in one go from
   // the stored frames and the start state; each step just reveals one more bit.
   logic [3:0] m_mem [DEPTH];
   int         m_wr = 0, m_tb = 0;
   logic [7:0] m_path = '0, m_frame = '0;
   logic       m_bit = 0, m_bv = 0, m_fv = 0;

   function automatic logic [7:0] trace_block(input logic [1:0] st);
      logic [7:0] p;
      logic [1:0] s;
      logic [3:0] row;
      p = '0;
      s = st;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         row  = m_mem[i];
         p[i] = s[1];
         s    = {s[0], row[s]};
      end
      return p;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_wr = 0; m_tb = 0; m_bit = 0; m_bv = 0; m_fv = 0; m_frame = '0;
      end else begin
         m_bv = 0;
         m_fv = 0;
         if (we) begin
            if (m_wr < DEPTH) begin
               m_mem[m_wr] = surv_in;
               m_wr++;
               if (m_wr == DEPTH) m_tb = DEPTH;
            end
         end else if (te && m_tb > 0) begin
            if (m_tb == DEPTH) m_path = trace_block(start_state);
            m_frame[m_tb-1] = m_path[m_tb-1];
            if (oe) begin
               m_bit = m_path[m_tb-1];
               m_bv  = 1;
            end
            m_tb--;
            if (m_tb == 0) begin
               m_fv = 1;
               m_wr = 0;
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus capture of serial output.
   logic sbits [$];
   int   fv_cnt = 0;

   initial forever begin
      @(negedge clk);
      check("cmp_wr_cnt", wr_cnt, m_wr);
      check("cmp_tb_cnt", tb_cnt, m_tb);
      check("cmp_bit_out", bit_out, m_bit);
      check("cmp_bit_valid", bit_valid, m_bv);
      check("cmp_frame_out", frame_out, m_frame);
      check("cmp_frame_valid", frame_valid, m_fv);
      if (bit_valid) sbits.push_back(bit_out);
      if (frame_valid) fv_cnt++;
   end

   task automatic cyc(input logic w, input logic t, input logic o,
                      input logic [3:0] s, input logic [1:0] st);
      we = w; te = t; oe = o; surv_in = s; start_state = st;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_capture();
      sbits.delete();
      fv_cnt = 0;
   endtask

   logic [3:0] rows_c [DEPTH];
   logic       exp_b  [DEPTH];

   initial begin
      rows_c = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h9, 4'h6, 4'hF, 4'h0};
      exp_b  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_cnt", wr_cnt, 0);
      check("rst_tb_cnt", tb_cnt, 0);
      check("rst_frame_out", frame_out, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_frame_valid", frame_valid, 0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 4'h0, 2'b00);

      // Block A: all-ones survivors from state 3 decode to all ones.
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 0, 0, 4'hF, 2'b00);
         check("a_wr_cnt", wr_cnt, i + 1);
      end
      check("a_tb_cnt_loaded", tb_cnt, 8);
      cyc(1, 0, 0, 4'h0, 2'b00);
      check("a_extra_write_wr_cnt", wr_cnt, 8);
      clear_capture();
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 1, 1, 4'h0, 2'b11);
         check("a_tb_cnt", tb_cnt, 7 - i);
      end
      check("a_wr_cnt_cleared", wr_cnt, 0);
      cyc(0, 0, 0, 4'h0, 2'b00);
      check("a_frame_out", frame_out, 8'hFF);
      check("a_frame_pulses", fv_cnt, 1);
      check("a_nbits", sbits.size(), 8);
      foreach (sbits[i]) check("a_serial_bit", sbits[i], 1);

      // Block B, back to back: zero survivors from state 1.
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 4'h0, 2'b00);
      clear_capture();
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, 4'h0, 2'b01);
      cyc(0, 0, 0, 4'h0, 2'b00);
      check("b_frame_out", frame_out, 8'h40);
      check("b_frame_pulses", fv_cnt, 1);
      check("b_nbits", sbits.size(), 8);
      for (int i = 0; i < DEPTH && i < sbits.size(); i++) check("b_serial_bit", sbits[i], exp_b[i]);

      // Block C: mixed survivors, traceback without serial output, stray commands.
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, rows_c[i], 2'b00);
      cyc(1, 0, 0, 4'h0, 2'b00);
      clear_capture();
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 4'h0, 2'b10);
      cyc(0, 1, 1, 4'h0, 2'b10);
      check("c_tb_cnt_idle", tb_cnt, 0);
      cyc(0, 0, 0, 4'h0, 2'b00);
      check("c_no_bit_valid", sbits.size(), 0);
      check("c_frame_pulses", fv_cnt, 1);

      // Block D: write collides with traceback, then reset mid-block.
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, rows_c[DEPTH-1-i], 2'b00);
      cyc(0, 1, 1, 4'h0, 2'b01);
      cyc(0, 1, 1, 4'h0, 2'b01);
      cyc(1, 1, 1, 4'h3, 2'b01);
      check("d_collision_tb_cnt", tb_cnt, 6);
      cyc(0, 1, 1, 4'h0, 2'b01);
      cyc(0, 1, 1, 4'h0, 2'b01);
      check("d_tb_cnt", tb_cnt, 4);
      #2 rst_n = 1'b0;
      #1;
      check("d_rst_wr_cnt", wr_cnt, 0);
      check("d_rst_tb_cnt", tb_cnt, 0);
      check("d_rst_bit_out", bit_out, 0);
      check("d_rst_frame_out", frame_out, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(0, 0, 0, 4'h0, 2'b00);

      // Block E after reset: survivors 0x5 from state 2 alternate 1,0,1,0...
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 4'h5, 2'b00);
      clear_capture();
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, 4'h0, 2'b10);
      cyc(0, 0, 0, 4'h0, 2'b00);
      check("e_frame_out", frame_out, 8'hAA);
      check("e_frame_pulses", fv_cnt, 1);
      check("e_nbits", sbits.size(), 8);
      foreach (sbits[i]) check("e_serial_bit", sbits[i], (i % 2) == 0);

      repeat (2) cyc(0, 0, 0, 4'h0, 2'b00);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
